// File: rtl/uart_echo_pkg.sv
// Shared TX FSM encoding and ASCII constants for the UART echo controller.
// State LF exists only when UART_ECHO_CRLF_EN is defined.
package uart_echo_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3
`ifdef UART_ECHO_CRLF_EN
    ,
    LF      = 3'd4
`endif
  } tx_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read and an occupancy count.
// The reset is synchronous and active-low. Memory contents are not reset.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullLvl = (PtrW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]     fill_q, fill_d;
  logic              do_push, do_pop;

  assign full  = (fill_q == FullLvl);
  assign empty = (fill_q == '0);
  assign fill  = fill_q;
  assign dout  = mem_q[rd_ptr_q];

  // A pop from an empty FIFO is ignored, so a same-cycle push to empty is not bypassed.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   fill_d = fill_q + (PtrW + 1)'(1);
      2'b01:   fill_d = fill_q - (PtrW + 1)'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/uart_echo_fifo.sv
// Buffered UART echo: RX words are queued and replayed to uart_tx with a START/BUSY handshake.
// Define UART_ECHO_CRLF_EN to append LF after every transmitted CR.
module uart_echo_fifo
  import uart_echo_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   RX_VALID,
  input  logic [DATA_W-1:0]      RX_DATA,
  input  logic                   TX_BUSY,
  output logic                   TX_START,
  output logic [DATA_W-1:0]      TX_DATA,
  output logic [DATA_W-1:0]      LAST_DATA,
  output logic [$clog2(DEPTH):0] FILL,
  output logic [CNT_W-1:0]       RX_CNT,
  output logic [CNT_W-1:0]       DROP_CNT,
  output logic                   OVERFLOW
);

  tx_state_e         state_q, state_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [DATA_W-1:0] last_data_q, last_data_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              overflow_q, overflow_d;

  logic                   fifo_push, fifo_pop;
  logic [DATA_W-1:0]      fifo_dout;
  logic [$clog2(DEPTH):0] fifo_fill;
  logic                   fifo_full, fifo_empty;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (RX_DATA),
    .dout   (fifo_dout),
    .fill   (fifo_fill),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // TX_START is registered: it is raised on the transition into LOAD so it is high exactly in LOAD.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !TX_BUSY) begin
          fifo_pop   = 1'b1;
          tx_data_d  = fifo_dout;
          tx_start_d = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (TX_BUSY) begin
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!TX_BUSY) begin
`ifdef UART_ECHO_CRLF_EN
          if (tx_data_q == DATA_W'(ASCII_CR)) begin
            state_d = LF;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef UART_ECHO_CRLF_EN
      LF: begin
        tx_data_d  = DATA_W'(ASCII_LF);
        tx_start_d = 1'b1;
        state_d    = LOAD;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    fifo_push   = RX_VALID && (!fifo_full || fifo_pop);
    rx_cnt_d    = rx_cnt_q;
    last_data_d = last_data_q;
    drop_cnt_d  = drop_cnt_q;
    overflow_d  = overflow_q;
    if (fifo_push) begin
      rx_cnt_d    = rx_cnt_q + CNT_W'(1);
      last_data_d = RX_DATA;
    end else if (RX_VALID) begin
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      last_data_q <= '0;
      rx_cnt_q    <= '0;
      drop_cnt_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      last_data_q <= last_data_d;
      rx_cnt_q    <= rx_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  assign TX_START  = tx_start_q;
  assign TX_DATA   = tx_data_q;
  assign LAST_DATA = last_data_q;
  assign FILL      = fifo_fill;
  assign RX_CNT    = rx_cnt_q;
  assign DROP_CNT  = drop_cnt_q;
  assign OVERFLOW  = overflow_q;

endmodule
